airi5c_dm_regaccess: RTL and testbench
======================================

// Module: airi5c_dm_regaccess
// PURPOSE
//  Debug-module abstract-command engine for "Access Register" (cmdtype 0) commands.
//  Accepts a command word from the DMI command register, checks it against hart state,
//  and drives the register file debug port to move data between data0 and a GPR/FPR.
//  Sits inside the debug module, between the DMI register block and the register file.
// PARAMETERS
//  HAS_FPU   0   1: regno 0x1020-0x103F map to FPRs (dm_sel_fpu_reg_o=1); 0: unsupported
//  NUM_GPR   32  32, or 16 for RV32E; regno 0x1000+NUM_GPR..0x101F unsupported
// PORTS
//  clk_i             in   1   clock
//  rst_ni            in   1   reset, asynchronous, active-low
//  cmd_valid_i       in   1   1-cycle pulse: DMI write to the command register
//  cmd_i             in   32  command word written
//  cmd_o             out  32  command register readback (regno post-incremented)
//  data0_we_i        in   1   DMI write to data0
//  data0_wd_i        in   32  data0 write value
//  data0_o           out  32  data0 contents
//  cmderr_clr_i      in   3   write-1-to-clear mask for cmderr
//  cmderr_o          out  3   abstractcs.cmderr
//  busy_o            out  1   abstractcs.busy
//  done_o            out  1   1-cycle pulse at command completion (success or error)
//  halted_i          in   1   hart halted status
//  dm_wara_o         out  5   regfile debug port address
//  dm_wd_o           out  32  regfile debug write data (= data0)
//  dm_wen_o          out  1   regfile debug write enable
//  dm_sel_fpu_reg_o  out  1   regfile debug port targets the FPR bank
//  dm_rd_i           in   32  regfile debug read data (combinational from dm_wara_o)
// BEHAVIOUR
//  Reset: state IDLE; cmd_o, data0_o, dm_wd_o = 0; cmderr_o = 0; busy_o, done_o,
//   dm_wen_o, dm_sel_fpu_reg_o = 0; dm_wara_o = 0. Reset mid-command aborts at once:
//   dm_wen_o drops asynchronously, no partial write, no regno update.
//  Command fields: [31:24] cmdtype, [22:20] aarsize, [19] postincrement, [18] postexec,
//   [17] transfer, [16] write, [15:0] regno.
//  FSM IDLE -> DECODE -> ACCESS -> DONE -> IDLE; busy_o = 1 in DECODE, ACCESS and DONE.
//  IDLE: on cmd_valid_i with cmderr_o == 0 (value before this edge's clear), latch
//   cmd_i into cmd_o and go to DECODE. If cmderr_o != 0, ignore the command; cmd_o is
//   unchanged.
//  DECODE, checked in order, first match wins:
//   cmdtype != 0, aarsize != 2, or postexec = 1 -> cmderr 2.
//   transfer = 1 with unsupported regno -> cmderr 2.
//   halted_i = 0 -> cmderr 4.
//   On error, go to DONE (no access, no postincrement). On transfer = 0, go to DONE.
//   Otherwise go to ACCESS.
//  ACCESS, one cycle: dm_wara_o = regno[4:0]; dm_sel_fpu_reg_o = regno[5].
//   write = 1: dm_wen_o = 1 for exactly this cycle, dm_wd_o = data0.
//   write = 0: data0 <= dm_rd_i at the closing edge.
//  DONE: done_o = 1. If postincrement = 1 and the command had no error,
//   cmd_o[15:0] <= cmd_o[15:0] + 1 (16-bit wrap, 0xFFFF -> 0x0000). Next state IDLE.
//  Outside ACCESS: dm_wen_o = 0, dm_wara_o = 0, dm_sel_fpu_reg_o = 0.
//  Latency: cmd_valid_i at edge N -> busy_o high in cycles N+1..N+3 -> done_o in N+3.
//   An error exits via DONE, so busy_o is high in N+1..N+2.
//  cmd_valid_i while busy_o = 1: set cmderr 1 if cmderr_o == 0; the running command
//   completes unaffected.
//  data0_we_i while busy_o = 1: write ignored; set cmderr 1 if cmderr_o == 0.
//   Otherwise data0 <= data0_wd_i.
//  cmderr is written only while it is 0. cmderr_clr_i clears bits every cycle.
//   Same-edge set and clear: clear wins.
// TESTING
//  halted, data0=0x12345678, cmd 0x00231005 -> dm_wen_o=1 one cycle (N+2), wara=5,
//   wd=0x12345678, done_o at N+3, cmderr=0.
//  halted, dm_rd_i=0xCAFEF00D, cmd 0x00221005 -> no dm_wen_o, data0_o=0xCAFEF00D after
//   N+2, busy_o low at N+4.
//  cmd 0x002A101F -> read x31; cmd_o[15:0]=0x1020 afterwards. Issue again with HAS_FPU=0
//   -> cmderr=2, regno stays 0x1020.
//  halted_i=0, cmd 0x00231005 -> cmderr=4, no write. Next cmd ignored until
//   cmderr_clr_i=3'b111.
//  cmd 0x00331005 -> cmderr=2. With NUM_GPR=16, cmd 0x00221010 -> cmderr=2.
//   HAS_FPU=1, cmd 0x00231021 -> wen with sel_fpu=1, wara=1.
//  cmd_valid_i and data0_we_i during busy -> cmderr=1, data0 unchanged, first command
//   completes. Assert rst_ni in ACCESS -> dm_wen_o=0 immediately, all outputs at reset.

Source files
------------

// File: rtl/airi5c_dm_regaccess_if.sv
// Signal bundle between the DMI register block / register file and the
// abstract-command "Access Register" engine.
interface airi5c_dm_regaccess_if;
    logic        cmd_valid_i;
    logic [31:0] cmd_i;
    logic [31:0] cmd_o;
    logic        data0_we_i;
    logic [31:0] data0_wd_i;
    logic [31:0] data0_o;
    logic [2:0]  cmderr_clr_i;
    logic [2:0]  cmderr_o;
    logic        busy_o;
    logic        done_o;
    logic        halted_i;
    logic [4:0]  dm_wara_o;
    logic [31:0] dm_wd_o;
    logic        dm_wen_o;
    logic        dm_sel_fpu_reg_o;
    logic [31:0] dm_rd_i;

    modport master (
        output cmd_valid_i, cmd_i, data0_we_i, data0_wd_i, cmderr_clr_i, halted_i, dm_rd_i,
        input  cmd_o, data0_o, cmderr_o, busy_o, done_o,
               dm_wara_o, dm_wd_o, dm_wen_o, dm_sel_fpu_reg_o
    );

    modport slave (
        input  cmd_valid_i, cmd_i, data0_we_i, data0_wd_i, cmderr_clr_i, halted_i, dm_rd_i,
        output cmd_o, data0_o, cmderr_o, busy_o, done_o,
               dm_wara_o, dm_wd_o, dm_wen_o, dm_sel_fpu_reg_o
    );
endinterface

// File: rtl/airi5c_dm_regaccess.sv
// Abstract "Access Register" command engine: validates a command against hart
// state and moves data between data0 and a GPR/FPR through the regfile debug port.
module airi5c_dm_regaccess #(
    parameter bit HAS_FPU = 1'b0,
    parameter int NUM_GPR = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    airi5c_dm_regaccess_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, DECODE, ACCESS, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] cmd_q;
    logic [31:0] data0_q;
    logic [2:0]  cmderr_q, cmderr_d;
    logic [2:0]  err_code;
    logic        err_q, err_d;
    logic        busy;
    logic        accept;

    // GPRs live at 0x1000.., FPRs at 0x1020..0x103F
    function automatic logic regno_supported(input logic [15:0] regno);
        logic gpr_ok;
        logic fpr_ok;
        gpr_ok = (regno[15:5] == 11'h080) && (int'(regno[4:0]) < NUM_GPR);
        fpr_ok = HAS_FPU && (regno[15:5] == 11'h081);
        return gpr_ok || fpr_ok;
    endfunction

    assign busy   = (state_q != IDLE);
    assign accept = (state_q == IDLE) && bus.cmd_valid_i && (cmderr_q == 3'd0);

    always_comb begin
        state_d              = state_q;
        err_d                = err_q;
        err_code             = 3'd0;
        bus.dm_wen_o         = 1'b0;
        bus.dm_wara_o        = 5'd0;
        bus.dm_sel_fpu_reg_o = 1'b0;
        bus.done_o           = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = DECODE;
            end
            DECODE: begin
                if ((cmd_q[31:24] != 8'd0) || (cmd_q[22:20] != 3'd2) || cmd_q[18])
                    err_code = 3'd2;
                else if (cmd_q[17] && !regno_supported(cmd_q[15:0]))
                    err_code = 3'd2;
                else if (!bus.halted_i)
                    err_code = 3'd4;
                err_d   = (err_code != 3'd0);
                state_d = (err_d || !cmd_q[17]) ? DONE : ACCESS;
            end
            ACCESS: begin
                bus.dm_wara_o        = cmd_q[4:0];
                bus.dm_sel_fpu_reg_o = cmd_q[5];
                bus.dm_wen_o         = cmd_q[16];
                state_d              = DONE;
            end
            DONE: begin
                bus.done_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A sticky error is only ever written from zero; the clear mask is applied last
    always_comb begin
        cmderr_d = cmderr_q;
        if (cmderr_q == 3'd0) begin
            if (err_code != 3'd0)
                cmderr_d = err_code;
            else if (busy && (bus.cmd_valid_i || bus.data0_we_i))
                cmderr_d = 3'd1;
        end
        cmderr_d = cmderr_d & ~bus.cmderr_clr_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            err_q    <= 1'b0;
            cmderr_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            cmderr_q <= cmderr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q <= 32'd0;
        end else if (accept) begin
            cmd_q <= bus.cmd_i;
        end else if ((state_q == DONE) && cmd_q[19] && !err_q) begin
            cmd_q[15:0] <= cmd_q[15:0] + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data0_q <= 32'd0;
        end else if ((state_q == ACCESS) && !cmd_q[16]) begin
            data0_q <= bus.dm_rd_i;
        end else if (bus.data0_we_i && !busy) begin
            data0_q <= bus.data0_wd_i;
        end
    end

    assign bus.busy_o   = busy;
    assign bus.cmd_o    = cmd_q;
    assign bus.data0_o  = data0_q;
    assign bus.cmderr_o = cmderr_q;
    assign bus.dm_wd_o  = data0_q;

endmodule

// File: tb/tb_airi5c_dm_regaccess.sv
// Bench for airi5c_dm_regaccess: two parameterisations driven in lockstep,
// each checked against a transaction-level model of the command rules.
module tb_airi5c_dm_regaccess;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    airi5c_dm_regaccess_if ifc0 ();
    airi5c_dm_regaccess_if ifc1 ();

    airi5c_dm_regaccess #(.HAS_FPU(1'b0), .NUM_GPR(32)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifc0));
    airi5c_dm_regaccess #(.HAS_FPU(1'b1), .NUM_GPR(16)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifc1));

    logic [31:0] gpr [2][32];
    logic [31:0] fpr [2][32];

    always_comb ifc0.dm_rd_i = ifc0.dm_sel_fpu_reg_o ? fpr[0][ifc0.dm_wara_o] : gpr[0][ifc0.dm_wara_o];
    always_comb ifc1.dm_rd_i = ifc1.dm_sel_fpu_reg_o ? fpr[1][ifc1.dm_wara_o] : gpr[1][ifc1.dm_wara_o];

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_cmd    [2];
    logic [31:0] m_data0  [2];
    logic [2:0]  m_cmderr [2];

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        wen;
        logic        sel;
        logic [4:0]  wara;
        logic [31:0] wd;
        logic [31:0] cmd;
        logic [31:0] data0;
        logic [2:0]  cmderr;
    } obs_t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic obs_t observe(input int i);
        obs_t o;
        if (i == 0) begin
            o.busy = ifc0.busy_o;  o.done = ifc0.done_o;  o.wen = ifc0.dm_wen_o;
            o.sel = ifc0.dm_sel_fpu_reg_o;  o.wara = ifc0.dm_wara_o;  o.wd = ifc0.dm_wd_o;
            o.cmd = ifc0.cmd_o;  o.data0 = ifc0.data0_o;  o.cmderr = ifc0.cmderr_o;
        end else begin
            o.busy = ifc1.busy_o;  o.done = ifc1.done_o;  o.wen = ifc1.dm_wen_o;
            o.sel = ifc1.dm_sel_fpu_reg_o;  o.wara = ifc1.dm_wara_o;  o.wd = ifc1.dm_wd_o;
            o.cmd = ifc1.cmd_o;  o.data0 = ifc1.data0_o;  o.cmderr = ifc1.cmderr_o;
        end
        return o;
    endfunction

    task automatic drive(input logic cv, input logic [31:0] c, input logic we,
                         input logic [31:0] wd, input logic [2:0] clr, input logic h);
        ifc0.cmd_valid_i = cv;  ifc0.cmd_i = c;  ifc0.data0_we_i = we;
        ifc0.data0_wd_i = wd;   ifc0.cmderr_clr_i = clr;  ifc0.halted_i = h;
        ifc1.cmd_valid_i = cv;  ifc1.cmd_i = c;  ifc1.data0_we_i = we;
        ifc1.data0_wd_i = wd;   ifc1.cmderr_clr_i = clr;  ifc1.halted_i = h;
    endtask

    // Instance 0: 32 GPRs, no FPU. Instance 1: 16 GPRs plus FPU.
    function automatic bit model_supported(input int i, input logic [15:0] regno);
        int idx;
        idx = int'(regno) - 32'h1000;
        if (idx >= 0 && idx < ((i == 1) ? 16 : 32)) return 1'b1;
        if (i == 1 && idx >= 32 && idx < 64) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] model_err(input int i, input logic [31:0] c, input logic h);
        if (c[31:24] != 8'd0 || c[22:20] != 3'd2 || c[18]) return 3'd2;
        if (c[17] && !model_supported(i, c[15:0])) return 3'd2;
        if (!h) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [31:0] model_read(input int i, input logic [15:0] regno);
        int idx;
        idx = int'(regno) - 32'h1000;
        return (idx < 32) ? gpr[i][idx] : fpr[i][idx - 32];
    endfunction

    task automatic check_regs(input string tag);
        obs_t o;
        for (int i = 0; i < 2; i++) begin
            o = observe(i);
            check_eq($sformatf("%s%0d.cmd", tag, i), o.cmd, m_cmd[i]);
            check_eq($sformatf("%s%0d.data0", tag, i), o.data0, m_data0[i]);
            check_eq($sformatf("%s%0d.cmderr", tag, i), {29'd0, o.cmderr}, {29'd0, m_cmderr[i]});
        end
    endtask

    task automatic write_data0(input logic [31:0] v);
        drive(1'b0, 32'd0, 1'b1, v, 3'd0, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1);
        for (int i = 0; i < 2; i++) m_data0[i] = v;
    endtask

    task automatic clear(input logic [2:0] mask);
        drive(1'b0, 32'd0, 1'b0, 32'd0, mask, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1);
        for (int i = 0; i < 2; i++) m_cmderr[i] = m_cmderr[i] & ~mask;
    endtask

    // Issue one command; optional violations and clear mask land on the third edge
    task automatic do_cmd(input string tag, input logic [31:0] c, input logic h,
                          input logic [2:0] clr0, input logic inj_cv, input logic inj_we,
                          input logic [31:0] wv, input logic [2:0] clr2);
        bit         acc [2];
        bit         access [2];
        logic [2:0] err [2];
        int         last [2];
        obs_t       o;
        for (int i = 0; i < 2; i++) begin
            acc[i]      = (m_cmderr[i] == 3'd0);
            err[i]      = acc[i] ? model_err(i, c, h) : 3'd0;
            access[i]   = acc[i] && (err[i] == 3'd0) && c[17];
            last[i]     = !acc[i] ? 0 : (access[i] ? 3 : 2);
            m_cmderr[i] = m_cmderr[i] & ~clr0;
            if (acc[i]) m_cmd[i] = c;
        end
        if (!(acc[0] && acc[1])) inj_cv = 1'b0;
        drive(1'b1, c, 1'b0, 32'd0, clr0, h);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                o = observe(i);
                check_eq($sformatf("%s%0d.busy@%0d", tag, i, cyc), {31'd0, o.busy},
                         {31'd0, acc[i] && cyc <= last[i]});
                check_eq($sformatf("%s%0d.done@%0d", tag, i, cyc), {31'd0, o.done},
                         {31'd0, acc[i] && cyc == last[i]});
                check_eq($sformatf("%s%0d.wen@%0d", tag, i, cyc), {31'd0, o.wen},
                         {31'd0, access[i] && c[16] && cyc == 2});
                check_eq($sformatf("%s%0d.wara@%0d", tag, i, cyc), {27'd0, o.wara},
                         (access[i] && cyc == 2) ? {27'd0, c[4:0]} : 32'd0);
                check_eq($sformatf("%s%0d.sel@%0d", tag, i, cyc), {31'd0, o.sel},
                         (access[i] && cyc == 2) ? {31'd0, c[5]} : 32'd0);
                if (access[i] && c[16] && cyc == 2)
                    check_eq($sformatf("%s%0d.wd", tag, i), o.wd, m_data0[i]);
            end
            if (cyc == 2) drive(inj_cv, $urandom, inj_we, wv, clr2, h);
            else          drive(1'b0, 32'd0, 1'b0, 32'd0, 3'd0, h);
        end
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                m_cmderr[i] = err[i];
                if (m_cmderr[i] == 3'd0 && (inj_cv || inj_we)) m_cmderr[i] = 3'd1;
                if (access[i] && !c[16]) m_data0[i] = model_read(i, c[15:0]);
                if (err[i] == 3'd0 && c[19]) m_cmd[i][15:0] = m_cmd[i][15:0] + 16'd1;
            end else if (inj_we) begin
                m_data0[i] = wv;
            end
            m_cmderr[i] = m_cmderr[i] & ~clr2;
        end
        check_regs(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t        o;
        logic [31:0] c;
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 32; j++) begin
                gpr[i][j] = $urandom;
                fpr[i][j] = $urandom;
            end
            m_cmd[i] = 32'd0;  m_data0[i] = 32'd0;  m_cmderr[i] = 3'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            o = observe(i);
            check_eq($sformatf("rst%0d.busy", i), {31'd0, o.busy}, 32'd0);
            check_eq($sformatf("rst%0d.done", i), {31'd0, o.done}, 32'd0);
            check_eq($sformatf("rst%0d.wen", i), {31'd0, o.wen}, 32'd0);
            check_eq($sformatf("rst%0d.wara", i), {27'd0, o.wara}, 32'd0);
            check_eq($sformatf("rst%0d.sel", i), {31'd0, o.sel}, 32'd0);
            check_eq($sformatf("rst%0d.wd", i), o.wd, 32'd0);
        end
        check_regs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        write_data0(32'h12345678);
        do_cmd("wr_x5", 32'h00231005, 1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        gpr[0][5] = 32'hCAFEF00D;
        gpr[1][5] = 32'hCAFEF00D;
        do_cmd("rd_x5", 32'h00221005, 1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        check_eq("rd_x5_value", ifc0.data0_o, 32'hCAFEF00D);
        do_cmd("rd_x31", 32'h002A101F, 1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        check_eq("x31_postinc", {16'd0, ifc0.cmd_o[15:0]}, 32'h00001020);
        do_cmd("rd_f0_nofpu", 32'h002A1020, 1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        check_eq("nofpu_err", {29'd0, ifc0.cmderr_o}, 32'd2);
        check_eq("nofpu_regno", {16'd0, ifc0.cmd_o[15:0]}, 32'h00001020);
        clear(3'b111);
        do_cmd("not_halted", 32'h00231005, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        do_cmd("ignored", 32'h00231005, 1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        check_eq("sticky_err4", {29'd0, ifc0.cmderr_o}, 32'd4);
        clear(3'b111);
        do_cmd("aarsize3", 32'h00331005, 1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        clear(3'b111);
        do_cmd("rd_x16", 32'h00221010, 1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        clear(3'b111);
        do_cmd("wr_f1", 32'h00231021, 1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        clear(3'b111);
        do_cmd("busy_viol", 32'h00231005, 1'b1, 3'd0, 1'b1, 1'b1, 32'hDEADBEEF, 3'd0);
        check_eq("busy_viol_err", {29'd0, ifc0.cmderr_o}, 32'd1);
        clear(3'b111);
        do_cmd("set_vs_clr", 32'h00231005, 1'b1, 3'd0, 1'b1, 1'b0, 32'd0, 3'b001);
        do_cmd("wrap", 32'h0028FFFF, 1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        check_eq("wrap_regno", {16'd0, ifc0.cmd_o[15:0]}, 32'd0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 3) clear(3'($urandom));
            c = 32'd0;
            c[31:24] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            c[23]    = 1'($urandom);
            c[22:20] = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd2;
            c[19]    = 1'($urandom);
            c[18]    = ($urandom_range(0, 9) == 0);
            c[17]    = ($urandom_range(0, 5) != 0);
            c[16]    = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       c[15:0] = 16'($urandom);
                1:       c[15:0] = 16'hFFFF;
                default: c[15:0] = 16'h1000 + 16'($urandom_range(0, 63));
            endcase
            do_cmd($sformatf("rnd%0d_", n), c, ($urandom_range(0, 7) != 0),
                   ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd0,
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), $urandom,
                   ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd0);
        end

        // Reset taken while both instances are writing in ACCESS
        clear(3'b111);
        drive(1'b1, 32'h00231005, 1'b0, 32'd0, 3'd0, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1);
        @(negedge clk);
        check_eq("pre_rst.wen0", {31'd0, ifc0.dm_wen_o}, 32'd1);
        check_eq("pre_rst.wen1", {31'd0, ifc1.dm_wen_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            o = observe(i);
            m_cmd[i] = 32'd0;  m_data0[i] = 32'd0;  m_cmderr[i] = 3'd0;
            check_eq($sformatf("arst%0d.wen", i), {31'd0, o.wen}, 32'd0);
            check_eq($sformatf("arst%0d.busy", i), {31'd0, o.busy}, 32'd0);
            check_eq($sformatf("arst%0d.wara", i), {27'd0, o.wara}, 32'd0);
            check_eq($sformatf("arst%0d.sel", i), {31'd0, o.sel}, 32'd0);
            check_eq($sformatf("arst%0d.wd", i), o.wd, 32'd0);
        end
        check_regs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_cmd("post_rst", 32'h00221003, 1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
